brom_responder: RTL and testbench

BROM_RESPONDER -- requirements
Module: brom_responder

---
 rtl/drac_pkg.sv | 20 ++
 rtl/brom_rom_array.sv | 25 ++
 rtl/brom_responder.sv | 106 ++++++++++
 tb/tb_brom_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared boot-ROM types and constants for the fetch-side boot ROM responder.
// The boot image is generated by brom_image_word so the ROM needs no external file.
package drac_pkg;

  localparam int unsigned BROM_SIZE = 32'h0008_0000;

  typedef enum logic {
    IDLE,
    BUSY
  } brom_state_t;

  typedef logic [16:0] brom_word_idx_t;
  typedef logic [31:0] brom_data_t;

  // Boot image contents: word index folded into both halves, then scrambled.
  function automatic brom_data_t brom_image_word(input brom_word_idx_t idx);
    return {idx[14:0], idx} ^ 32'hDEAD_BEEF;
  endfunction

endpackage

// File: rtl/brom_rom_array.sv
// Synchronous single-port boot ROM with a one-cycle read latency.
// The output register only updates on en_i, so it holds the last word read.
module brom_rom_array
  import drac_pkg::*;
#(
  parameter int unsigned WORDS = BROM_SIZE / 4
) (
  input  logic        clk_i,
  input  logic        en_i,
  input  logic [16:0] addr_i,
  output logic [31:0] data_o
);

  brom_data_t r_data;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if ({15'd0, addr_i} < WORDS) r_data <= brom_image_word(addr_i);
      else                         r_data <= '0;
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/brom_responder.sv
// Boot ROM responder: accepts one fetch request at a time and answers it exactly
// READ_LATENCY cycles later, flagging accesses beyond the boot ROM as errors.
module brom_responder
  import drac_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ROM_WORDS    = BROM_SIZE / 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        brom_req_valid_i,
  input  logic [23:0] brom_req_address_i,
  input  logic        brom_kill_i,
  output logic        brom_ready_o,
  output logic        brom_resp_valid_o,
  output logic [31:0] brom_resp_data_o,
  output logic        brom_resp_error_o
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  brom_state_t    r_state, w_stateNext;
  logic [2:0]     r_latCnt, w_latCntNext;
  brom_word_idx_t r_idx, w_idxNext;
  logic           r_oob, w_oobNext;
  brom_data_t     r_lastData;

  brom_word_idx_t w_reqIdx;
  logic           w_reqOob;
  logic           w_respCycle;
  logic           w_respFire;
  logic           w_accept;
  logic           w_romEn;
  brom_word_idx_t w_romAddr;
  brom_data_t     w_romData;
  brom_data_t     w_respData;

  assign w_reqIdx = brom_req_address_i[18:2];
  assign w_reqOob = ({8'd0, brom_req_address_i} >= BROM_SIZE);

  // lat_cnt==1 marks the response cycle; a new request may be accepted in it.
  assign w_respCycle  = (r_state == BUSY) && (r_latCnt == 3'd1);
  assign brom_ready_o = ~brom_kill_i & ((r_state == IDLE) | w_respCycle);
  assign w_accept     = brom_req_valid_i & brom_ready_o;
  assign w_respFire   = w_respCycle & ~brom_kill_i;

  // The ROM read is issued one cycle ahead of the response; with latency 1
  // that is the acceptance cycle itself, addressed straight from the request.
  assign w_romEn   = (w_accept & (LAT == 3'd1) & ~w_reqOob)
                   | ((r_state == BUSY) & (r_latCnt == 3'd2) & ~r_oob & ~brom_kill_i);
  assign w_romAddr = w_accept ? w_reqIdx : r_idx;

  brom_rom_array #(
    .WORDS(ROM_WORDS)
  ) u_rom (
    .clk_i (clk_i),
    .en_i  (w_romEn),
    .addr_i(w_romAddr),
    .data_o(w_romData)
  );

  assign w_respData        = r_oob ? '0 : w_romData;
  assign brom_resp_valid_o = w_respFire;
  assign brom_resp_data_o  = w_respFire ? w_respData : r_lastData;
  assign brom_resp_error_o = w_respFire & r_oob;

  always_comb begin
    w_stateNext  = r_state;
    w_latCntNext = r_latCnt;
    w_idxNext    = r_idx;
    w_oobNext    = r_oob;
    if (brom_kill_i) begin
      w_stateNext  = IDLE;
      w_latCntNext = 3'd0;
    end else if (w_accept) begin
      w_stateNext  = BUSY;
      w_latCntNext = LAT;
      w_idxNext    = w_reqIdx;
      w_oobNext    = w_reqOob;
    end else if (r_state == BUSY) begin
      if (r_latCnt == 3'd1) begin
        w_stateNext  = IDLE;
        w_latCntNext = 3'd0;
      end else begin
        w_latCntNext = r_latCnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_latCnt   <= 3'd0;
      r_idx      <= '0;
      r_oob      <= 1'b0;
      r_lastData <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_latCnt <= w_latCntNext;
      r_idx    <= w_idxNext;
      r_oob    <= w_oobNext;
      if (w_respFire) r_lastData <= w_respData;
    end
  end

endmodule

// File: tb/tb_brom_responder.sv
// Bench for brom_responder: four instances with latencies 1..4 share one clock and
// reset; a timestamp-based model checks every instance on every falling edge.
module tb_brom_responder;

  localparam int NINST = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        reqValid [NINST];
  logic [23:0] reqAddr  [NINST];
  logic        kill     [NINST];
  logic        ready    [NINST];
  logic        respValid[NINST];
  logic [31:0] respData [NINST];
  logic        respErr  [NINST];
  logic [NINST-1:0] romEn;

  int tests = 0;
  int fails = 0;
  int romEnCount = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : genDut
    brom_responder #(
      .READ_LATENCY(g + 1)
    ) u_dut (
      .clk_i             (clk),
      .rstn_i            (rstn),
      .brom_req_valid_i  (reqValid[g]),
      .brom_req_address_i(reqAddr[g]),
      .brom_kill_i       (kill[g]),
      .brom_ready_o      (ready[g]),
      .brom_resp_valid_o (respValid[g]),
      .brom_resp_data_o  (respData[g]),
      .brom_resp_error_o (respErr[g])
    );
    assign romEn[g] = u_dut.u_rom.en_i;
  end

  always @(posedge clk) if (romEn[2]) romEnCount++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Boot image as seen by the fetch side: low half index, upper bits repeat it, scrambled.
  function automatic logic [31:0] romModel(input int idx);
    return 32'((((idx & 'h7FFF) << 17) | idx) ^ 32'hDEADBEEF);
  endfunction

  // Model: each instance has at most one outstanding fetch, due at an absolute cycle.
  bit          mActive[NINST];
  int          mDue   [NINST];
  logic [31:0] mWord  [NINST];
  bit          mErr   [NINST];
  logic [31:0] mLast  [NINST];
  int          cyc = 0;

  always @(negedge clk) begin
    for (int g = 0; g < NINST; g++) begin
      bit          expReady, responding;
      logic [31:0] expData;
      int          a;
      if (!rstn) begin
        mActive[g] = 0;
        mLast[g]   = '0;
        checkOutput($sformatf("rstReady%0d@%0d", g, cyc), {31'd0, ready[g]}, {31'd0, !kill[g]});
        checkOutput($sformatf("rstValid%0d@%0d", g, cyc), {31'd0, respValid[g]}, 0);
        checkOutput($sformatf("rstData%0d@%0d", g, cyc), respData[g], 0);
        checkOutput($sformatf("rstErr%0d@%0d", g, cyc), {31'd0, respErr[g]}, 0);
      end else begin
        responding = mActive[g] && (mDue[g] == cyc) && !kill[g];
        expReady   = !kill[g] && (!mActive[g] || mDue[g] == cyc);
        expData    = responding ? mWord[g] : mLast[g];
        checkOutput($sformatf("ready%0d@%0d", g, cyc), {31'd0, ready[g]}, {31'd0, expReady});
        checkOutput($sformatf("valid%0d@%0d", g, cyc), {31'd0, respValid[g]}, {31'd0, responding});
        checkOutput($sformatf("data%0d@%0d", g, cyc), respData[g], expData);
        checkOutput($sformatf("err%0d@%0d", g, cyc), {31'd0, respErr[g]},
                    {31'd0, responding && mErr[g]});
        if (responding) mLast[g] = mWord[g];
        if (kill[g]) begin
          mActive[g] = 0;
        end else if (reqValid[g] && expReady) begin
          a          = int'(reqAddr[g]);
          mActive[g] = 1;
          mDue[g]    = cyc + g + 1;
          mErr[g]    = (a >= 'h80000);
          mWord[g]   = mErr[g] ? 32'h0 : romModel((a >> 2) & 'h1FFFF);
        end else if (mActive[g] && mDue[g] == cyc) begin
          mActive[g] = 0;
        end
      end
    end
    cyc++;
  end

  task automatic applyStimulus(input int g, input logic v, input logic [23:0] a, input logic k);
    @(posedge clk);
    #1;
    for (int i = 0; i < NINST; i++) begin
      reqValid[i] = 1'b0;
      reqAddr[i]  = '0;
      kill[i]     = 1'b0;
    end
    reqValid[g] = v;
    reqAddr[g]  = a;
    kill[g]     = k;
    @(negedge clk);
  endtask

  logic [31:0] bLits[3] = '{32'hDEADBEEF, 32'hDEAFBEEE, 32'hDEA9BEED};
  logic [23:0] bAddr;
  int          snap;

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < NINST; i++) begin
      reqValid[i] = 1'b0;
      reqAddr[i]  = '0;
      kill[i]     = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", {31'd0, ready[0]}, 1);

    // Latency 1: single fetch of word 0.
    applyStimulus(0, 1'b1, 24'h000000, 1'b0);
    checkOutput("l1ReadyAccept", {31'd0, ready[0]}, 1);
    applyStimulus(0, 1'b0, 24'h0, 1'b0);
    checkOutput("l1Valid", {31'd0, respValid[0]}, 1);
    checkOutput("l1Data", respData[0], 32'hDEADBEEF);
    checkOutput("l1Err", {31'd0, respErr[0]}, 0);
    checkOutput("l1Ready", {31'd0, ready[0]}, 1);

    // Latency 1: back-to-back fetches of words 0, 1, 2.
    for (int k = 0; k < 4; k++) begin
      bAddr = 24'(k * 4);
      applyStimulus(0, k < 3, bAddr, 1'b0);
      if (k > 0) begin
        checkOutput($sformatf("b2bValid%0d", k), {31'd0, respValid[0]}, 1);
        checkOutput($sformatf("b2bData%0d", k), respData[0], bLits[k-1]);
      end
    end

    // Kill together with valid: not accepted, data holds.
    applyStimulus(0, 1'b1, 24'h000020, 1'b1);
    checkOutput("killValidReady", {31'd0, ready[0]}, 0);
    applyStimulus(0, 1'b0, 24'h0, 1'b0);
    checkOutput("killValidNoResp", {31'd0, respValid[0]}, 0);
    checkOutput("killValidHold", respData[0], 32'hDEA9BEED);

    // Latency 3: word 4, ready low in cycles 1-2.
    applyStimulus(2, 1'b1, 24'h000010, 1'b0);
    applyStimulus(2, 1'b0, 24'h0, 1'b0);
    checkOutput("l3ReadyC1", {31'd0, ready[2]}, 0);
    applyStimulus(2, 1'b0, 24'h0, 1'b0);
    checkOutput("l3ReadyC2", {31'd0, ready[2]}, 0);
    applyStimulus(2, 1'b0, 24'h0, 1'b0);
    checkOutput("l3ReadyC3", {31'd0, ready[2]}, 1);
    checkOutput("l3ValidC3", {31'd0, respValid[2]}, 1);
    checkOutput("l3DataC3", respData[2], 32'hDEA5BEEB);

    // Reset in cycle 1 of a latency-3 fetch drops it.
    applyStimulus(2, 1'b1, 24'h000010, 1'b0);
    @(posedge clk);
    #1;
    reqValid[2] = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("midRstData", respData[2], 0);
    checkOutput("midRstValid", {31'd0, respValid[2]}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2, 1'b0, 24'h0, 1'b0);
      checkOutput($sformatf("postRstValid%0d", k), {31'd0, respValid[2]}, 0);
      checkOutput($sformatf("postRstReady%0d", k), {31'd0, ready[2]}, 1);
      checkOutput($sformatf("postRstData%0d", k), respData[2], 0);
    end

    // Out-of-range fetch on latency 3: error response, ROM never read.
    snap = romEnCount;
    applyStimulus(2, 1'b1, 24'h080000, 1'b0);
    applyStimulus(2, 1'b0, 24'h0, 1'b0);
    applyStimulus(2, 1'b0, 24'h0, 1'b0);
    applyStimulus(2, 1'b0, 24'h0, 1'b0);
    checkOutput("oobValid", {31'd0, respValid[2]}, 1);
    checkOutput("oobData", respData[2], 0);
    checkOutput("oobErr", {31'd0, respErr[2]}, 1);
    applyStimulus(2, 1'b0, 24'h0, 1'b0);
    checkOutput("oobErrAfter", {31'd0, respErr[2]}, 0);
    checkOutput("oobRomEn", 32'(romEnCount - snap), 0);

    // Latency 2: kill in cycle 1, fresh request in cycle 2 served normally.
    applyStimulus(1, 1'b1, 24'h00000C, 1'b0);
    applyStimulus(1, 1'b0, 24'h0, 1'b1);
    checkOutput("killC1Valid", {31'd0, respValid[1]}, 0);
    applyStimulus(1, 1'b1, 24'h000014, 1'b0);
    checkOutput("killC2Valid", {31'd0, respValid[1]}, 0);
    checkOutput("killC2Ready", {31'd0, ready[1]}, 1);
    applyStimulus(1, 1'b0, 24'h0, 1'b0);
    checkOutput("killC3Valid", {31'd0, respValid[1]}, 0);
    applyStimulus(1, 1'b0, 24'h0, 1'b0);
    checkOutput("killC4Valid", {31'd0, respValid[1]}, 1);
    checkOutput("killC4Data", respData[1], 32'hDEA7BEEA);

    // Latency 2: kill exactly in the response cycle suppresses it.
    applyStimulus(1, 1'b1, 24'h00000C, 1'b0);
    applyStimulus(1, 1'b0, 24'h0, 1'b0);
    applyStimulus(1, 1'b0, 24'h0, 1'b1);
    checkOutput("killRespValid", {31'd0, respValid[1]}, 0);
    checkOutput("killRespHold", respData[1], 32'hDEA7BEEA);
    applyStimulus(1, 1'b0, 24'h0, 1'b0);
    checkOutput("killRespLate", {31'd0, respValid[1]}, 0);

    // Latency 4: word 3 with ignored byte-offset bits.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(3, k == 0, 24'h00000F, 1'b0);
      if (k == 4) begin
        checkOutput("l4Valid", {31'd0, respValid[3]}, 1);
        checkOutput("l4Data", respData[3], 32'hDEABBEEC);
      end
    end

    applyStimulus(0, 1'b0, 24'h0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
